// File: rtl/minirisc_pkg.sv
`default_nettype none
// minirisc_pkg: opcode constants and issuer state encoding.
// This package is shared by the minirisc core and the opcode issuer.
package minirisc_pkg;

  localparam logic [7:0] OP_IDLE  = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_STORE = 8'h04;
  localparam logic [7:0] OP_MAX   = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } issuer_state_e;

endpackage
`default_nettype wire

// File: rtl/minirisc_prog_mem.sv
`default_nettype none
// minirisc_prog_mem: DEPTH x OP_W register file for the opcode program.
// It has one synchronous write port and one combinational read port; storage is not reset.
module minirisc_prog_mem #(
  parameter int DEPTH = 8,
  parameter int OP_W  = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [OP_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [OP_W-1:0] rdata
);

  logic [OP_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/minirisc_op_issuer.sv
`default_nettype none
// minirisc_op_issuer: buffers a host-loaded opcode program.
// On start it replays the program one entry per clock and then pulses done.
module minirisc_op_issuer
  import minirisc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OP_W  = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             wr_valid,
  input  logic [OP_W-1:0]  wr_data,
  output logic             wr_ready,
  input  logic             start,
  input  logic             clr,
  output logic [OP_W-1:0]  op_out,
  output logic             op_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [OP_W-1:0]  OP_MAX_W = OP_W'(OP_MAX);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

  issuer_state_e    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [OP_W-1:0]  op_out_q, op_out_d;
  logic             op_valid_q, op_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             wr_accept;
  logic             wr_illegal;
  logic [OP_W-1:0]  wr_clean;
  logic [AW-1:0]    rd_addr;
  logic [OP_W-1:0]  rd_data;

  assign wr_ready   = (state_q == ST_IDLE) && (count_q < DEPTH_C) && ena;
  assign wr_accept  = wr_valid && wr_ready && !clr;
  assign wr_illegal = wr_data > OP_MAX_W;
  assign wr_clean   = wr_illegal ? '0 : wr_data;
  assign rd_addr    = (state_q == ST_RUN) ? rd_ptr_q[AW-1:0] : '0;

  minirisc_prog_mem #(
    .DEPTH (DEPTH),
    .OP_W  (OP_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (wr_clean),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    op_out_d   = op_out_q;
    op_valid_d = op_valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    if (ena) begin
      done_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (clr) begin
            count_d  = '0;
            wr_ptr_d = '0;
            err_d    = 1'b0;
          end else begin
            if (wr_accept) begin
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              count_d  = count_q + CNT_ONE;
              err_d    = err_q | wr_illegal;
            end
            if (start) begin
              if (count_d != '0) begin
                // Entry 0 may be written on this very edge; bypass the buffer then.
                state_d    = ST_RUN;
                op_out_d   = (count_q == '0) ? wr_clean : rd_data;
                op_valid_d = 1'b1;
                busy_d     = 1'b1;
                rd_ptr_d   = CNT_ONE;
              end else begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (clr) begin
            state_d    = ST_IDLE;
            op_out_d   = '0;
            op_valid_d = 1'b0;
            busy_d     = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            err_d      = 1'b0;
          end else if (rd_ptr_q == count_q) begin
            state_d    = ST_DONE;
            op_out_d   = '0;
            op_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            op_out_d = rd_data;
            rd_ptr_d = rd_ptr_q + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          if (clr) begin
            count_d  = '0;
            wr_ptr_d = '0;
            err_d    = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      op_out_q   <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      op_out_q   <= op_out_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign op_out   = op_out_q;
  assign op_valid = op_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_minirisc_op_issuer.sv
`default_nettype none
// tb_minirisc_op_issuer: directed plus random stimulus for the opcode issuer.
// A queue-based program model supplies the expected value of every output on each cycle.
module tb_minirisc_op_issuer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic       wr_ready, op_valid, busy, done, err;
  logic [7:0] op_out;
  logic [3:0] count;

  minirisc_op_issuer #(.DEPTH(DEPTH), .OP_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .start    (start),
    .clr      (clr),
    .op_out   (op_out),
    .op_valid (op_valid),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .count    (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the stored program, the index being issued (-1 when none), a done flag.
  logic [7:0] prog[$];
  int         pos = -1;
  bit         m_done = 1'b0;
  bit         m_err = 1'b0;

  logic [7:0] seen[$];
  int         done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_seen(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
      chk(name, seen[i], exp[i]);
    end
  endtask

  always @(negedge rst_n) begin
    prog.delete();
    pos    = -1;
    m_done = 1'b0;
    m_err  = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n && ena) begin
      if (m_done) begin
        m_done = 1'b0;
        if (clr) begin
          prog.delete();
          m_err = 1'b0;
        end
      end else if (pos >= 0) begin
        if (clr) begin
          pos = -1;
          prog.delete();
          m_err = 1'b0;
        end else if (pos + 1 < prog.size()) begin
          pos++;
        end else begin
          pos    = -1;
          m_done = 1'b1;
        end
      end else if (clr) begin
        prog.delete();
        m_err = 1'b0;
      end else begin
        if (wr_valid && prog.size() < DEPTH) begin
          if (wr_data > 8'h04) begin
            prog.push_back(8'h00);
            m_err = 1'b1;
          end else begin
            prog.push_back(wr_data);
          end
        end
        if (start) begin
          if (prog.size() > 0) pos = 0;
          else m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("op_valid", op_valid, int'(pos >= 0));
      chk("op_out", op_out, (pos >= 0) ? int'(prog[pos]) : 0);
      chk("busy", busy, int'(pos >= 0));
      chk("done", done, int'(m_done));
      chk("err", err, int'(m_err));
      chk("count", count, prog.size());
      chk("wr_ready", wr_ready, int'(pos < 0 && !m_done && prog.size() < DEPTH && ena));
      if (op_valid) seen.push_back(op_out);
      if (done) done_cnt++;
    end
  end

  task automatic cyc(input bit wv, input logic [7:0] wd, input bit st, input bit cl, input bit en);
    wr_valid = wv;
    wr_data  = wd;
    start    = st;
    clr      = cl;
    ena      = en;
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic write4();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic arm();
    seen.delete();
    done_cnt = 0;
  endtask

  logic [7:0] vals9[9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h03, 8'h02, 8'h01, 8'h03};

  initial begin
    repeat (2) @(posedge clk);
    #3;
    chk("rst_op_out", op_out, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    idle(1);

    // Basic program replayed twice.
    write4();
    arm();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(6);
    chk_seen("replay1", '{8'h01, 8'h02, 8'h03, 8'h04});
    chk("replay1_done", done_cnt, 1);
    chk("replay1_count", count, 4);
    arm();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(6);
    chk_seen("replay2", '{8'h01, 8'h02, 8'h03, 8'h04});
    chk("replay2_done", done_cnt, 1);

    // Fill past capacity.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b1, vals9[i], 1'b0, 1'b0, 1'b1);
    chk("full_count", count, 8);
    chk("full_wr_ready", wr_ready, 0);
    arm();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(10);
    chk_seen("full_replay", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h03, 8'h02, 8'h01});

    // Illegal opcode stored as 0x00 and flagged.
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 8'h07, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    chk("illegal_err", err, 1);
    arm();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(4);
    chk_seen("illegal_replay", '{8'h00, 8'h02});
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("clr_err", err, 0);
    chk("clr_count", count, 0);

    // Empty start: done on the very next cycle, nothing issued.
    arm();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("empty_done_n1", done, 1);
    idle(1);
    chk("empty_done_n2", done, 0);
    idle(2);
    chk("empty_done_cnt", done_cnt, 1);
    chk("empty_seen", seen.size(), 0);

    // Abort on the second issue cycle.
    write4();
    arm();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("abort_valid", op_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 0);
    chk("abort_wr_ready", wr_ready, 1);
    idle(4);
    chk("abort_done_cnt", done_cnt, 0);
    chk_seen("abort_seen", '{8'h01, 8'h02});

    // Clock-enable stall after the first issue.
    write4();
    arm();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk_seen("stall_seen", '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04});
    chk("stall_done_cnt", done_cnt, 1);

    // Asynchronous reset in the middle of a replay.
    arm();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("arst_op_out", op_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", op_valid, 0);
    chk("arst_done", done, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    done_cnt = 0;
    idle(3);
    chk("arst_done_cnt", done_cnt, 0);
    chk("arst_count", count, 0);

    // Random traffic against the model.
    repeat (800) begin
      cyc($urandom_range(0, 9) < 4,
          ($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4)),
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 49) == 0,
          $urandom_range(0, 9) != 0);
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
